// File: rtl/lm75a_i2c_reader.sv
// LM75A temperature reader: I2C master fetching the 16-bit register at pointer 0x00.
// Open-drain bus: *_oe=1 pulls the line low, 0 releases it.
module lm75a_i2c_reader #(
  parameter int         CLK_HZ      = 50_000_000,
  parameter int         SCL_HZ      = 100_000,
  parameter logic [6:0] DEV_ADDR    = 7'h48,
  parameter int         POLL_CYCLES = 25_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sda_i,
  output logic        sda_oe,
  output logic        scl_oe,
  output logic [15:0] data,
  output logic        data_valid,
  output logic        busy,
  output logic        ack_err
);
  localparam int QTR = CLK_HZ / (4 * SCL_HZ);
  localparam int QW = (QTR > 1) ? $clog2(QTR) : 1;
  localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam logic [QW-1:0] Q_LAST = QW'(QTR - 1);
  localparam logic [PW-1:0] POLL_MAX = PW'(POLL_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR_W, S_ACK_W, S_PTR, S_ACK_P,
    S_RSTART, S_ADDR_R, S_ACK_R, S_RD_MSB, S_MACK,
    S_RD_LSB, S_MNACK, S_STOP, S_DONE
  } state_t;

  state_t        r_state;
  logic [1:0]    r_sync;
  logic [QW-1:0] r_qcnt;
  logic [1:0]    r_q;
  logic [2:0]    r_bit;
  logic [7:0]    r_tx;
  logic [15:0]   r_rx;
  logic [PW-1:0] r_poll;
  logic          r_nack;

  logic w_tick;
  logic w_poll_hit;
  logic w_sda;
  logic w_tx_st;
  logic w_ack_st;
  logic w_rd_st;
  logic w_q0_sda;

  assign w_tick     = (r_qcnt == Q_LAST);
  assign w_poll_hit = (POLL_CYCLES != 0) && (r_poll == POLL_MAX);
  assign w_sda      = r_sync[1];
  assign w_tx_st    = (r_state == S_ADDR_W) || (r_state == S_PTR) ||
                      (r_state == S_ADDR_R);
  assign w_ack_st   = (r_state == S_ACK_W) || (r_state == S_ACK_P) ||
                      (r_state == S_ACK_R);
  assign w_rd_st    = (r_state == S_RD_MSB) || (r_state == S_RD_LSB);
  // SDA level set up while SCL is low at the start of each bit
  assign w_q0_sda   = w_tx_st ? ~r_tx[7] :
                      ((r_state == S_STOP) || (r_state == S_MACK));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], sda_i};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_qcnt     <= '0;
      r_q        <= '0;
      r_bit      <= '0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_poll     <= '0;
      r_nack     <= 1'b0;
      sda_oe     <= 1'b0;
      scl_oe     <= 1'b0;
      data       <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      ack_err    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (r_state == S_IDLE) begin
        r_qcnt <= '0;
        r_q    <= '0;
        r_bit  <= '0;
        if (start || w_poll_hit) begin
          r_state <= S_START;
          busy    <= 1'b1;
          ack_err <= 1'b0;
          r_nack  <= 1'b0;
          r_tx    <= {DEV_ADDR, 1'b0};
          r_poll  <= '0;
        end else if (POLL_CYCLES != 0) begin
          r_poll <= r_poll + 1'b1;
        end
      end else begin
        // an expiry during a transfer is held so one auto-read follows
        if ((POLL_CYCLES != 0) && !w_poll_hit) r_poll <= r_poll + 1'b1;
        r_qcnt <= w_tick ? '0 : r_qcnt + 1'b1;
        if (r_state == S_DONE) begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end else if (w_tick) begin
          r_q <= r_q + 2'd1;
          unique case (r_q)
            2'd0: sda_oe <= w_q0_sda;
            2'd1: scl_oe <= 1'b0;
            2'd2: begin
              if ((r_state == S_START) || (r_state == S_RSTART))
                sda_oe <= 1'b1;
              if (r_state == S_STOP) sda_oe <= 1'b0;
              if (w_ack_st) begin
                r_nack <= w_sda;
                if (w_sda) ack_err <= 1'b1;
              end
              if (w_rd_st) r_rx <= {r_rx[14:0], w_sda};
            end
            2'd3: begin
              scl_oe <= (r_state != S_STOP);
              if (w_tx_st || w_rd_st) r_bit <= r_bit + 3'd1;
              if (w_tx_st) r_tx <= {r_tx[6:0], 1'b0};
              unique case (r_state)
                S_START:  r_state <= S_ADDR_W;
                S_ADDR_W: if (r_bit == 3'd7) r_state <= S_ACK_W;
                S_ACK_W: begin
                  r_state <= r_nack ? S_STOP : S_PTR;
                  r_tx    <= 8'h00;
                end
                S_PTR:    if (r_bit == 3'd7) r_state <= S_ACK_P;
                S_ACK_P:  r_state <= r_nack ? S_STOP : S_RSTART;
                S_RSTART: begin
                  r_state <= S_ADDR_R;
                  r_tx    <= {DEV_ADDR, 1'b1};
                end
                S_ADDR_R: if (r_bit == 3'd7) r_state <= S_ACK_R;
                S_ACK_R:  r_state <= r_nack ? S_STOP : S_RD_MSB;
                S_RD_MSB: if (r_bit == 3'd7) r_state <= S_MACK;
                S_MACK:   r_state <= S_RD_LSB;
                S_RD_LSB: if (r_bit == 3'd7) r_state <= S_MNACK;
                S_MNACK:  r_state <= S_STOP;
                S_STOP: begin
                  r_state <= S_DONE;
                  if (!r_nack) begin
                    data       <= r_rx;
                    data_valid <= 1'b1;
                  end
                end
                default:  r_state <= S_IDLE;
              endcase
            end
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_lm75a_i2c_reader.sv
// Bench for lm75a_i2c_reader: behavioural LM75A slave on an open-drain bus.
// A second instance with a short poll period and no slave covers auto-read.
module tb_lm75a_i2c_reader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic sda_oe, scl_oe, data_valid, busy, ack_err;
  logic [15:0] data;
  logic scl_w, sda_w;

  logic p_start = 1'b0;
  logic p_sda_oe, p_scl_oe, p_dv, p_busy, p_ack_err;
  logic [15:0] p_data;
  logic p_sda_w;

  logic s_pull = 1'b0;
  logic s_act = 1'b0;
  logic s_rw = 1'b0;
  int s_k = 0;
  logic [7:0] s_sh = 8'h00;
  logic [7:0] s_msb = 8'h00;
  logic [7:0] s_lsb = 8'h00;
  logic s_nack_addr = 1'b0;
  logic p_scl = 1'b1;
  logic p_sda = 1'b1;
  int log_q[$];
  logic mack_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign scl_w = ~scl_oe;
  assign sda_w = ~(sda_oe | s_pull);
  assign p_sda_w = ~p_sda_oe;

  lm75a_i2c_reader #(
    .CLK_HZ(2_000_000), .SCL_HZ(100_000),
    .DEV_ADDR(7'h48), .POLL_CYCLES(0)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .sda_i(sda_w),
    .sda_oe(sda_oe), .scl_oe(scl_oe), .data(data),
    .data_valid(data_valid), .busy(busy), .ack_err(ack_err)
  );

  lm75a_i2c_reader #(
    .CLK_HZ(2_000_000), .SCL_HZ(100_000),
    .DEV_ADDR(7'h48), .POLL_CYCLES(2000)
  ) dut_poll (
    .clk(clk), .rst(rst), .start(p_start), .sda_i(p_sda_w),
    .sda_oe(p_sda_oe), .scl_oe(p_scl_oe), .data(p_data),
    .data_valid(p_dv), .busy(p_busy), .ack_err(p_ack_err)
  );

  // Slave: logs S/P and master bytes, ACKs writes, returns s_msb/s_lsb
  always @(scl_w or sda_w or rst) begin
    int n, b;
    if (rst) begin
      s_act = 1'b0;
      s_pull = 1'b0;
    end else if (p_scl && scl_w && p_sda && !sda_w) begin
      s_act = 1'b1;
      s_k = -1;
      s_rw = 1'b0;
      s_pull = 1'b0;
      log_q.push_back(256);
    end else if (p_scl && scl_w && !p_sda && sda_w) begin
      if (s_act) log_q.push_back(512);
      s_act = 1'b0;
      s_pull = 1'b0;
    end else if (s_act && !p_scl && scl_w) begin
      n = s_k / 9;
      b = s_k % 9;
      if (n <= 2 && b < 8 && (n == 0 || !s_rw)) begin
        s_sh = {s_sh[6:0], sda_w};
        if (b == 7) begin
          log_q.push_back(int'(s_sh));
          if (n == 0) s_rw = s_sh[0];
        end
      end
      if (s_rw && (n == 1 || n == 2) && b == 8) mack_q.push_back(sda_w);
    end else if (s_act && p_scl && !scl_w) begin
      s_k++;
      n = s_k / 9;
      b = s_k % 9;
      if (n == 0 && b == 8) s_pull = !s_nack_addr;
      else if (n == 1 && b == 8 && !s_rw) s_pull = 1'b1;
      else if (s_rw && n == 1 && b < 8) s_pull = ~s_msb[7-b];
      else if (s_rw && n == 2 && b < 8) s_pull = ~s_lsb[7-b];
      else s_pull = 1'b0;
    end
    p_scl = scl_w;
    p_sda = sda_w;
  end

  function automatic string log_str();
    string s = "";
    foreach (log_q[i]) begin
      if (log_q[i] == 256) s = {s, "S "};
      else if (log_q[i] == 512) s = {s, "P "};
      else s = {s, $sformatf("%02h ", log_q[i][7:0])};
    end
    return s;
  endfunction

  function automatic string mack_str();
    string s = "";
    foreach (mack_q[i]) s = {s, $sformatf("%b", mack_q[i])};
    return s;
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(output int dv, output bit to);
    dv = 0;
    to = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (data_valid) dv++;
      if (!busy) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic p_rise(output int t, output bit to);
    logic pb;
    t = 0;
    to = 1'b1;
    pb = p_busy;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (p_busy && !pb) begin
        t = cyc;
        to = 1'b0;
        break;
      end
      pb = p_busy;
    end
  endtask

  task automatic setup_slave(input logic [7:0] msb,
                             input logic [7:0] lsb,
                             input logic nack);
    s_msb = msb;
    s_lsb = lsb;
    s_nack_addr = nack;
    log_q.delete();
    mack_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (sda_oe !== 1'b0) begin
      failures++; $display("FAIL rst_sda_oe got=%b exp=0", sda_oe);
    end
    checks++;
    if (scl_oe !== 1'b0) begin
      failures++; $display("FAIL rst_scl_oe got=%b exp=0", scl_oe);
    end
    checks++;
    if (data !== 16'h0000) begin
      failures++; $display("FAIL rst_data got=%h exp=0000", data);
    end
    checks++;
    if (data_valid !== 1'b0) begin
      failures++; $display("FAIL rst_dv got=%b exp=0", data_valid);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL rst_busy got=%b exp=0", busy);
    end
    checks++;
    if (ack_err !== 1'b0) begin
      failures++; $display("FAIL rst_ack_err got=%b exp=0", ack_err);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_good_read();
    int dv;
    bit to;
    setup_slave(8'h19, 8'h80, 1'b0);
    pulse_start();
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL good_busy got=%b exp=1", busy);
    end
    wait_idle(dv, to);
    checks++;
    if (to !== 1'b0) begin
      failures++; $display("FAIL good_timeout got=%b exp=0", to);
    end
    checks++;
    if (dv !== 1) begin
      failures++; $display("FAIL good_dv_count got=%0d exp=1", dv);
    end
    checks++;
    if (data !== 16'h1980) begin
      failures++; $display("FAIL good_data got=%h exp=1980", data);
    end
    checks++;
    if (ack_err !== 1'b0) begin
      failures++; $display("FAIL good_ack_err got=%b exp=0", ack_err);
    end
    checks++;
    if (log_str() != "S 90 00 S 91 P ") begin
      failures++;
      $display("FAIL good_bus got='%s' exp='S 90 00 S 91 P '", log_str());
    end
    checks++;
    if (mack_str() != "01") begin
      failures++; $display("FAIL good_mack got='%s' exp='01'", mack_str());
    end
    checks++;
    if ({sda_oe, scl_oe} !== 2'b00) begin
      failures++; $display("FAIL good_idle_lines got=%b exp=00", {sda_oe, scl_oe});
    end
  endtask

  task automatic test_nack();
    int dv;
    bit to;
    setup_slave(8'h55, 8'h00, 1'b1);
    pulse_start();
    wait_idle(dv, to);
    checks++;
    if (to !== 1'b0) begin
      failures++; $display("FAIL nack_timeout got=%b exp=0", to);
    end
    checks++;
    if (ack_err !== 1'b1) begin
      failures++; $display("FAIL nack_ack_err got=%b exp=1", ack_err);
    end
    checks++;
    if (data !== 16'h1980) begin
      failures++; $display("FAIL nack_data_kept got=%h exp=1980", data);
    end
    checks++;
    if (dv !== 0) begin
      failures++; $display("FAIL nack_dv_count got=%0d exp=0", dv);
    end
    checks++;
    if (log_str() != "S 90 P ") begin
      failures++; $display("FAIL nack_bus got='%s' exp='S 90 P '", log_str());
    end
    setup_slave(8'h0C, 8'h80, 1'b0);
    pulse_start();
    checks++;
    if (ack_err !== 1'b0) begin
      failures++; $display("FAIL nack_clear got=%b exp=0", ack_err);
    end
    wait_idle(dv, to);
    checks++;
    if (to !== 1'b0) begin
      failures++; $display("FAIL nack2_timeout got=%b exp=0", to);
    end
    checks++;
    if (data !== 16'h0C80) begin
      failures++; $display("FAIL nack2_data got=%h exp=0c80", data);
    end
    checks++;
    if (ack_err !== 1'b0 || dv !== 1) begin
      failures++;
      $display("FAIL nack2_status got=%b/%0d exp=0/1", ack_err, dv);
    end
  endtask

  task automatic test_negative();
    int dv;
    bit to;
    setup_slave(8'hE7, 8'h00, 1'b0);
    pulse_start();
    wait_idle(dv, to);
    checks++;
    if (to !== 1'b0 || dv !== 1) begin
      failures++; $display("FAIL neg_done got=%b/%0d exp=0/1", to, dv);
    end
    checks++;
    if (data !== 16'hE700) begin
      failures++; $display("FAIL neg_data got=%h exp=e700", data);
    end
    checks++;
    if (mack_str() != "01") begin
      failures++; $display("FAIL neg_mack got='%s' exp='01'", mack_str());
    end
  endtask

  task automatic test_back_to_back();
    int rises;
    int dv;
    logic pb;
    setup_slave(8'h19, 8'h80, 1'b0);
    rises = 0;
    dv = 0;
    pb = busy;
    for (int i = 0; i < 1200; i++) begin
      start = (i < 10) || ((i % 97) == 50 && i < 800);
      @(negedge clk);
      if (busy && !pb) rises++;
      if (data_valid) dv++;
      pb = busy;
    end
    start = 1'b0;
    checks++;
    if (rises !== 1) begin
      failures++; $display("FAIL b2b_transfers got=%0d exp=1", rises);
    end
    checks++;
    if (dv !== 1) begin
      failures++; $display("FAIL b2b_dv_count got=%0d exp=1", dv);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL b2b_busy got=%b exp=0", busy);
    end
    checks++;
    if (data !== 16'h1980) begin
      failures++; $display("FAIL b2b_data got=%h exp=1980", data);
    end
  endtask

  task automatic test_reset_mid();
    int dv;
    bit to;
    setup_slave(8'h19, 8'h80, 1'b0);
    pulse_start();
    to = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (log_q.size() >= 5) begin
        to = 1'b0;
        break;
      end
    end
    checks++;
    if (to !== 1'b0) begin
      failures++; $display("FAIL mid_reach_read got=%b exp=0", to);
    end
    repeat (40) @(negedge clk);
    for (int i = 0; i < 20 && !scl_oe; i++) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({sda_oe, scl_oe} !== 2'b00) begin
      failures++; $display("FAIL mid_lines got=%b exp=00", {sda_oe, scl_oe});
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL mid_busy got=%b exp=0", busy);
    end
    checks++;
    if (data !== 16'h0000) begin
      failures++; $display("FAIL mid_data got=%h exp=0000", data);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    setup_slave(8'h19, 8'h80, 1'b0);
    pulse_start();
    wait_idle(dv, to);
    checks++;
    if (to !== 1'b0 || dv !== 1) begin
      failures++; $display("FAIL mid_after got=%b/%0d exp=0/1", to, dv);
    end
    checks++;
    if (data !== 16'h1980) begin
      failures++; $display("FAIL mid_after_data got=%h exp=1980", data);
    end
    checks++;
    if (log_str() != "S 90 00 S 91 P ") begin
      failures++;
      $display("FAIL mid_after_bus got='%s' exp='S 90 00 S 91 P '", log_str());
    end
  endtask

  task automatic test_poll();
    int t0, t1, t2;
    bit to0, to1, to2;
    p_rise(t0, to0);
    p_rise(t1, to1);
    p_rise(t2, to2);
    checks++;
    if ({to0, to1, to2} !== 3'b000) begin
      failures++; $display("FAIL poll_timeout got=%b exp=000", {to0, to1, to2});
    end
    checks++;
    if (t1 - t0 !== 2000) begin
      failures++; $display("FAIL poll_period1 got=%0d exp=2000", t1 - t0);
    end
    checks++;
    if (t2 - t1 !== 2000) begin
      failures++; $display("FAIL poll_period2 got=%0d exp=2000", t2 - t1);
    end
    repeat (300) @(negedge clk);
    checks++;
    if (p_ack_err !== 1'b1 || p_busy !== 1'b0) begin
      failures++;
      $display("FAIL poll_nack got=%b/%b exp=1/0", p_ack_err, p_busy);
    end
    checks++;
    if (p_data !== 16'h0000) begin
      failures++; $display("FAIL poll_data got=%h exp=0000", p_data);
    end
  endtask

  initial begin
    test_reset();
    test_good_read();
    test_nack();
    test_negative();
    test_back_to_back();
    test_reset_mid();
    test_poll();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
